// File: rtl/wb_sequencer_pkg.sv
// Shared types and constants for the writeback sequencer: bundle layout,
// register/data widths and the "live write" rule used by every port decision.
package wb_sequencer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  wen0;
        logic [REG_ADDR_W-1:0] waddr0;
        logic [DATA_W-1:0]     wdata0;
        logic                  wen1;
        logic [REG_ADDR_W-1:0] waddr1;
        logic [DATA_W-1:0]     wdata1;
    } wb_bundle_t;

    // A write only reaches the register file when enabled and not aimed at r0.
    function automatic logic port_live(input logic wen, input logic [REG_ADDR_W-1:0] waddr);
        return wen && (waddr != ZERO_REG);
    endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Bundle, register-file write, scoreboard and forwarding signals of the
// writeback sequencer; master = memory stage / decode side, slave = sequencer.
interface wb_sequencer_if
    import wb_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) ();

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_wen0;
    logic [REG_ADDR_W-1:0] in_waddr0;
    logic [DATA_W-1:0]     in_wdata0;
    logic                  in_wen1;
    logic [REG_ADDR_W-1:0] in_waddr1;
    logic [DATA_W-1:0]     in_wdata1;
    logic                  stall;
    logic                  wen0;
    logic [REG_ADDR_W-1:0] waddr0;
    logic [DATA_W-1:0]     wdata0;
    logic                  wen1;
    logic [REG_ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0]     wdata1;
    logic                  sb_set;
    logic [REG_ADDR_W-1:0] sb_addr;
    logic [REG_ADDR_W-1:0] raddr0;
    logic [REG_ADDR_W-1:0] raddr1;
    logic                  busy0;
    logic                  busy1;
    logic                  fwd_hit0;
    logic                  fwd_hit1;
    logic [DATA_W-1:0]     fwd_data0;
    logic [DATA_W-1:0]     fwd_data1;
    logic [CNT_W-1:0]      occupancy;

    modport master (
        output in_valid, in_wen0, in_waddr0, in_wdata0, in_wen1, in_waddr1, in_wdata1,
        output stall, sb_set, sb_addr, raddr0, raddr1,
        input  in_ready, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
        input  busy0, busy1, fwd_hit0, fwd_hit1, fwd_data0, fwd_data1, occupancy
    );

    modport slave (
        input  in_valid, in_wen0, in_waddr0, in_wdata0, in_wen1, in_waddr1, in_wdata1,
        input  stall, sb_set, sb_addr, raddr0, raddr1,
        output in_ready, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
        output busy0, busy1, fwd_hit0, fwd_hit1, fwd_data0, fwd_data1, occupancy
    );

endinterface

// File: rtl/wb_sequencer_fwd_match.sv
// wb_fwd_match: youngest buffered write to one source register, port 0 over
// port 1 within a bundle. Compiled only when WB_FORWARD_EN is defined.
`ifdef WB_FORWARD_EN
module wb_fwd_match
    import wb_sequencer_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  wb_bundle_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]       rd_ptr,
    input  logic [CNT_W-1:0]       count,
    input  logic [REG_ADDR_W-1:0]  raddr,
    output logic                   hit,
    output logic [DATA_W-1:0]      data
);

    wb_bundle_t       entry_s;
    logic [PTR_W-1:0] idx_s;
    logic             m0_s;
    logic             m1_s;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit     = 1'b0;
        data    = '0;
        entry_s = '0;
        idx_s   = '0;
        m0_s    = 1'b0;
        m1_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s   = rd_ptr + PTR_W'(i);
            entry_s = entries[idx_s];
            m0_s    = (CNT_W'(i) < count) && port_live(entry_s.wen0, entry_s.waddr0)
                      && (entry_s.waddr0 == raddr);
            m1_s    = (CNT_W'(i) < count) && port_live(entry_s.wen1, entry_s.waddr1)
                      && (entry_s.waddr1 == raddr);
            hit     = hit | m0_s | m1_s;
            data    = m0_s ? entry_s.wdata0 : (m1_s ? entry_s.wdata1 : data);
        end
    end

endmodule
`endif

// File: rtl/wb_sequencer.sv
// Writeback sequencer: bundle FIFO feeding both register-file write ports,
// pending-write scoreboard, and optional forwarding (define WB_FORWARD_EN).
module wb_sequencer
    import wb_sequencer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    wb_sequencer_if.slave bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    wb_bundle_t [DEPTH-1:0] mem_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [31:0]            busy_r;

    wb_bundle_t             in_bundle_s;
    wb_bundle_t             head_s;
    logic                   nonempty_s;
    logic                   in_ready_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   wen0_s;
    logic                   wen1_s;
    logic [REG_ADDR_W-1:0]  waddr0_s;
    logic [REG_ADDR_W-1:0]  waddr1_s;
    logic [DATA_W-1:0]      wdata0_s;
    logic [DATA_W-1:0]      wdata1_s;
    logic [31:0]            clr_mask_s;
    logic [31:0]            set_mask_s;

    assign in_bundle_s = '{wen0:   bus.in_wen0,   waddr0: bus.in_waddr0, wdata0: bus.in_wdata0,
                           wen1:   bus.in_wen1,   waddr1: bus.in_waddr1, wdata1: bus.in_wdata1};
    assign nonempty_s  = (count_r != '0);
    assign in_ready_s  = (count_r < DEPTH_C);
    assign push_s      = bus.in_valid && in_ready_s;
    assign pop_s       = nonempty_s && !bus.stall;
    assign head_s      = mem_r[rd_ptr_r];

    // Bundle FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_bundle_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_C;
                2'b01:   count_r <= count_r - ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head bundle to write ports; a same-register pair keeps only port 0.
    always_comb begin
        wen0_s   = 1'b0;
        wen1_s   = 1'b0;
        waddr0_s = '0;
        waddr1_s = '0;
        wdata0_s = '0;
        wdata1_s = '0;
        if (nonempty_s) begin
            waddr0_s = head_s.waddr0;
            waddr1_s = head_s.waddr1;
            wdata0_s = head_s.wdata0;
            wdata1_s = head_s.wdata1;
            wen0_s   = !bus.stall && port_live(head_s.wen0, head_s.waddr0);
            wen1_s   = !bus.stall && port_live(head_s.wen1, head_s.waddr1)
                       && !(wen0_s && (head_s.waddr1 == head_s.waddr0));
        end else begin
            wen0_s   = 1'b0;
            wen1_s   = 1'b0;
        end
    end

    assign clr_mask_s = (wen0_s ? (32'd1 << waddr0_s) : 32'd0)
                      | (wen1_s ? (32'd1 << waddr1_s) : 32'd0);
    assign set_mask_s = port_live(bus.sb_set, bus.sb_addr) ? (32'd1 << bus.sb_addr) : 32'd0;

    // Pending-write scoreboard; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.occupancy = count_r;
    assign bus.wen0      = wen0_s;
    assign bus.waddr0    = waddr0_s;
    assign bus.wdata0    = wdata0_s;
    assign bus.wen1      = wen1_s;
    assign bus.waddr1    = waddr1_s;
    assign bus.wdata1    = wdata1_s;
    assign bus.busy0     = (bus.raddr0 != ZERO_REG) && busy_r[bus.raddr0];
    assign bus.busy1     = (bus.raddr1 != ZERO_REG) && busy_r[bus.raddr1];

`ifdef WB_FORWARD_EN
    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd0 (
        .entries (mem_r),
        .rd_ptr  (rd_ptr_r),
        .count   (count_r),
        .raddr   (bus.raddr0),
        .hit     (bus.fwd_hit0),
        .data    (bus.fwd_data0)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (mem_r),
        .rd_ptr  (rd_ptr_r),
        .count   (count_r),
        .raddr   (bus.raddr1),
        .hit     (bus.fwd_hit1),
        .data    (bus.fwd_data1)
    );
`else
    assign bus.fwd_hit0  = 1'b0;
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_data0 = 32'd0;
    assign bus.fwd_data1 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed vector table, mid-operation
// reset sequence, then randomized traffic against a queue-based reference model.
module tb_wb_sequencer;
    import wb_sequencer_pkg::*;

    localparam int DEPTH = 2;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    wb_sequencer_if #(.DEPTH(DEPTH)) bus ();

    wb_sequencer #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit w0; bit [4:0] a0; bit [31:0] d0;
        bit w1; bit [4:0] a1; bit [31:0] d1;
    } bnd_t;

    typedef struct {
        bit vld; bnd_t b; bit st; bit sbs; bit [4:0] sba; bit [4:0] ra0;
        bit ew0; bit [4:0] ea0; bit [31:0] ed0;
        bit ew1; bit [4:0] ea1; bit [31:0] ed1;
        int eocc; bit erdy; bit eb0; bit eh0; bit [31:0] efd0;
    } vec_t;

    vec_t        tbl[$];
    bnd_t        q[$];
    bit   [31:0] busy_m;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic bnd_t mkb(int w0, int a0, int d0, int w1, int a1, int d1);
        bnd_t b;
        b.w0 = 1'(w0); b.a0 = 5'(a0); b.d0 = 32'(d0);
        b.w1 = 1'(w1); b.a1 = 5'(a1); b.d1 = 32'(d1);
        return b;
    endfunction

    function automatic vec_t mk(int vld, int w0, int a0, int d0, int w1, int a1, int d1,
                                int st, int sbs, int sba, int ra0,
                                int ew0, int ea0, int ed0, int ew1, int ea1, int ed1,
                                int eocc, int erdy, int eb0, int eh0, int efd0);
        vec_t v;
        v.vld = 1'(vld); v.b = mkb(w0, a0, d0, w1, a1, d1);
        v.st = 1'(st); v.sbs = 1'(sbs); v.sba = 5'(sba); v.ra0 = 5'(ra0);
        v.ew0 = 1'(ew0); v.ea0 = 5'(ea0); v.ed0 = 32'(ed0);
        v.ew1 = 1'(ew1); v.ea1 = 5'(ea1); v.ed1 = 32'(ed1);
        v.eocc = eocc; v.erdy = 1'(erdy); v.eb0 = 1'(eb0); v.eh0 = 1'(eh0); v.efd0 = 32'(efd0);
        return v;
    endfunction

    task automatic drive(bit vld, bnd_t b, bit st, bit sbs, bit [4:0] sba, bit [4:0] ra0, bit [4:0] ra1);
        bus.in_valid  = vld;
        bus.in_wen0   = b.w0; bus.in_waddr0 = b.a0; bus.in_wdata0 = b.d0;
        bus.in_wen1   = b.w1; bus.in_waddr1 = b.a1; bus.in_wdata1 = b.d1;
        bus.stall     = st;
        bus.sb_set    = sbs;
        bus.sb_addr   = sba;
        bus.raddr0    = ra0;
        bus.raddr1    = ra1;
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_occupancy"}, 32'(bus.occupancy), 32'd0);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, "_wen0"},      32'(bus.wen0),      32'd0);
        chk({tag, "_wen1"},      32'(bus.wen1),      32'd0);
        chk({tag, "_waddr0"},    32'(bus.waddr0),    32'd0);
        chk({tag, "_wdata0"},    32'(bus.wdata0),    32'd0);
        chk({tag, "_waddr1"},    32'(bus.waddr1),    32'd0);
        chk({tag, "_wdata1"},    32'(bus.wdata1),    32'd0);
        chk({tag, "_busy0"},     32'(bus.busy0),     32'd0);
        chk({tag, "_fwd_hit0"},  32'(bus.fwd_hit0),  32'd0);
    endtask

    // Reference: expected outputs from the model queue and scoreboard array.
    task automatic model_check();
        bit   e0, e1, h, bz;
        bnd_t hd;
        bit [4:0]  ra;
        bit [31:0] fd;
        e0 = 1'b0; e1 = 1'b0;
        if (q.size() > 0 && !bus.stall) begin
            hd = q[0];
            e0 = hd.w0 && hd.a0 != 5'd0;
            e1 = hd.w1 && hd.a1 != 5'd0 && !(e0 && hd.a1 == hd.a0);
        end
        chk("rnd_wen0", 32'(bus.wen0), 32'(e0));
        chk("rnd_wen1", 32'(bus.wen1), 32'(e1));
        if (e0) chk("rnd_wr0", {bus.waddr0, bus.wdata0[26:0]}, {hd.a0, hd.d0[26:0]});
        if (e1) chk("rnd_wr1", {bus.waddr1, bus.wdata1[26:0]}, {hd.a1, hd.d1[26:0]});
        chk("rnd_occupancy", 32'(bus.occupancy), 32'(q.size()));
        chk("rnd_in_ready",  32'(bus.in_ready),  32'(q.size() < DEPTH));
        for (int p = 0; p < 2; p++) begin
            ra = (p == 0) ? bus.raddr0 : bus.raddr1;
            bz = (ra != 5'd0) && busy_m[ra];
            h  = 1'b0; fd = 32'd0;
            for (int j = q.size() - 1; j >= 0 && !h; j--) begin
                if (q[j].w0 && q[j].a0 != 5'd0 && q[j].a0 == ra) begin h = 1'b1; fd = q[j].d0; end
                else if (q[j].w1 && q[j].a1 != 5'd0 && q[j].a1 == ra) begin h = 1'b1; fd = q[j].d1; end
            end
            h = h & FWD;
            chk($sformatf("rnd_busy%0d", p), 32'(p == 0 ? bus.busy0 : bus.busy1), 32'(bz));
            chk($sformatf("rnd_hit%0d", p), 32'(p == 0 ? bus.fwd_hit0 : bus.fwd_hit1), 32'(h));
            if (h) chk($sformatf("rnd_fwd_data%0d", p), p == 0 ? bus.fwd_data0 : bus.fwd_data1, fd);
        end
    endtask

    // Reference: advance the model across the coming clock edge.
    task automatic model_step();
        bit   rdy, e0, e1;
        bnd_t hd, nb;
        rdy = q.size() < DEPTH;
        e0 = 1'b0; e1 = 1'b0;
        if (q.size() > 0 && !bus.stall) begin
            hd = q.pop_front();
            e0 = hd.w0 && hd.a0 != 5'd0;
            e1 = hd.w1 && hd.a1 != 5'd0 && !(e0 && hd.a1 == hd.a0);
            if (e0) busy_m[hd.a0] = 1'b0;
            if (e1) busy_m[hd.a1] = 1'b0;
        end
        if (bus.sb_set && bus.sb_addr != 5'd0) busy_m[bus.sb_addr] = 1'b1;
        if (bus.in_valid && rdy) begin
            nb.w0 = bus.in_wen0; nb.a0 = bus.in_waddr0; nb.d0 = bus.in_wdata0;
            nb.w1 = bus.in_wen1; nb.a1 = bus.in_waddr1; nb.d1 = bus.in_wdata1;
            q.push_back(nb);
        end
    endtask

    initial begin
        bnd_t idle_b, rb;
        n_tests = 0;
        n_fail  = 0;
        idle_b  = mkb(0, 0, 0, 0, 0, 0);
        drive(1'b0, idle_b, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        rst_n = 1'b0;
        #12;
        chk_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table: inputs held for one cycle, expectations sampled before its edge.
        tbl.push_back(mk(1,1,5,'h11,0,0,0,       0,0,0,5,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,5,  1,5,'h11,0,0,0,       1,1,0,1,'h11));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,5,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,1,7,'hAA,1,7,'hBB,    0,0,0,7,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,7,  1,7,'hAA,0,0,0,       1,1,0,1,'hAA));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,7,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,1,1,'h101,0,0,0,      1,0,0,0,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,2,'h202,      1,0,0,0,  0,0,0,0,0,0,          1,1,0,0,0));
        tbl.push_back(mk(1,1,3,'h303,0,0,0,      1,0,0,0,  0,0,0,0,0,0,          2,0,0,0,0));
        tbl.push_back(mk(1,1,3,'h303,0,0,0,      0,0,0,0,  1,1,'h101,0,0,0,      2,0,0,0,0));
        tbl.push_back(mk(1,1,3,'h303,0,0,0,      0,0,0,0,  0,0,0,1,2,'h202,      1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,  1,3,'h303,0,0,0,      1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,1,9,9,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,1,9,'h99,0,0,0,       0,0,0,9,  0,0,0,0,0,0,          0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,9,  1,9,'h99,0,0,0,       1,1,1,1,'h99));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,9,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,1,9,9,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,1,9,'h9A,0,0,0,       0,0,0,9,  0,0,0,0,0,0,          0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,1,9,9,  1,9,'h9A,0,0,0,       1,1,1,1,'h9A));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,9,  0,0,0,0,0,0,          0,1,1,0,0));
        tbl.push_back(mk(1,1,9,'h9B,0,0,0,       0,0,0,9,  0,0,0,0,0,0,          0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,9,  1,9,'h9B,0,0,0,       1,1,1,1,'h9B));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,9,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,1,4,1,0,0,0,          1,0,0,4,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,4,2,          1,0,0,4,  0,0,0,0,0,0,          1,1,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,0,          1,0,0,4,  0,0,0,0,0,0,          2,0,0,1,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,4,  1,4,1,0,0,0,          2,0,0,1,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,4,  0,0,0,1,4,2,          1,1,0,1,2));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,4,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,1,0,5,1,0,6,          0,1,0,0,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,  0,0,0,0,0,0,          1,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,0,  0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(1,1,10,'hA0,1,11,'hB1,  0,0,0,11, 0,0,0,0,0,0,          0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,11, 1,10,'hA0,1,11,'hB1,  1,1,0,1,'hB1));
        tbl.push_back(mk(0,0,0,0,0,0,0,          0,0,0,11, 0,0,0,0,0,0,          0,1,0,0,0));

        foreach (tbl[i]) begin
            drive(tbl[i].vld, tbl[i].b, tbl[i].st, tbl[i].sbs, tbl[i].sba, tbl[i].ra0, 5'd0);
            @(negedge clk);
            chk($sformatf("v%0d_wen0", i), 32'(bus.wen0), 32'(tbl[i].ew0));
            if (tbl[i].ew0) chk($sformatf("v%0d_wr0", i), {bus.waddr0, bus.wdata0[26:0]},
                                {tbl[i].ea0, tbl[i].ed0[26:0]});
            chk($sformatf("v%0d_wen1", i), 32'(bus.wen1), 32'(tbl[i].ew1));
            if (tbl[i].ew1) chk($sformatf("v%0d_wr1", i), {bus.waddr1, bus.wdata1[26:0]},
                                {tbl[i].ea1, tbl[i].ed1[26:0]});
            chk($sformatf("v%0d_occupancy", i), 32'(bus.occupancy), 32'(tbl[i].eocc));
            chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].erdy));
            chk($sformatf("v%0d_busy0", i), 32'(bus.busy0), 32'(tbl[i].eb0));
            chk($sformatf("v%0d_busy1", i), 32'(bus.busy1), 32'd0);
            chk($sformatf("v%0d_hit0", i), 32'(bus.fwd_hit0), 32'(tbl[i].eh0 & FWD));
            chk($sformatf("v%0d_hit1", i), 32'(bus.fwd_hit1), 32'd0);
            if (tbl[i].eh0 & FWD) chk($sformatf("v%0d_fwd_data0", i), bus.fwd_data0, tbl[i].efd0);
            @(posedge clk); #1;
        end

        // Reset while two bundles are buffered and r12 is pending.
        drive(1'b1, mkb(1, 12, 'hC0, 0, 0, 0), 1'b1, 1'b1, 5'd12, 5'd12, 5'd0);
        @(posedge clk); #1;
        drive(1'b1, mkb(0, 0, 0, 1, 13, 'hD0), 1'b1, 1'b0, 5'd0, 5'd12, 5'd0);
        @(posedge clk); #1;
        drive(1'b0, idle_b, 1'b1, 1'b0, 5'd0, 5'd12, 5'd0);
        @(negedge clk);
        chk("prerst_occupancy", 32'(bus.occupancy), 32'd2);
        chk("prerst_busy0", 32'(bus.busy0), 32'd1);
        chk("prerst_hit0", 32'(bus.fwd_hit0), 32'(FWD));
        rst_n = 1'b0;
        bus.stall = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("inrst_wen0", 32'(bus.wen0), 32'd0);
            chk("inrst_wen1", 32'(bus.wen1), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_outputs("postrst");
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        q.delete();
        busy_m = 32'd0;
        for (int c = 0; c < 600; c++) begin
            rb = mkb(int'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom),
                     int'($urandom_range(1, 0)), int'($urandom_range(7, 0)), int'($urandom));
            drive(($urandom_range(99, 0) < 55), rb, ($urandom_range(99, 0) < 30),
                  ($urandom_range(99, 0) < 30), 5'($urandom_range(7, 0)),
                  5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)));
            @(negedge clk);
            model_check();
            model_step();
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
